// File: rtl/grid_issue_arbiter.sv
// Round-robin issue arbiter feeding a fixed-latency AND grid, with a credit-guarded
// show-ahead response FIFO. Define GRID_ARB_STATS_EN to add saturating issue/stall counters.
module grid_issue_arbiter #(
    parameter int NREQ      = 3,
    parameter int LAT       = 3,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [2:0]        grid_in,
    input  logic [2:0]        grid_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_data,
    output logic [1:0]        rsp_id
`ifdef GRID_ARB_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_stall
`endif
);

    localparam int PW = (RSP_DEPTH > 2) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + LAT + 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(RSP_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    logic [1:0]    last_grant_r;
    logic [LAT-1:0] sh_valid_r;
    logic [1:0]    sh_id_r [LAT];
    logic [4:0]    mem_r [RSP_DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [CW-1:0] count_r;

    logic [3:0]    valid_pad_s;
    logic [11:0]   data_pad_s;
    logic [CW-1:0] inflight_s;
    logic          credit_s;
    logic          found_s;
    logic          hit_s;
    logic [1:0]    cand_s;
    logic [1:0]    pick_s;
    logic [3:0]    grant_s;
    logic          transfer_s;
    logic          push_s;
    logic          pop_s;

    assign valid_pad_s = 4'(req_valid);
    assign data_pad_s  = 12'(req_data);

    // Credit check and round-robin pick starting one past the last winner.
    always_comb begin
        inflight_s = '0;
        for (int s = 0; s < LAT; s++) begin
            inflight_s = inflight_s + CW'(sh_valid_r[s]);
        end
        credit_s = (count_r + inflight_s) < CW'(RSP_DEPTH);
        found_s  = 1'b0;
        hit_s    = 1'b0;
        cand_s   = 2'd0;
        pick_s   = 2'd0;
        for (int off = 1; off <= NREQ; off++) begin
            cand_s  = 2'((int'(last_grant_r) + off) % NREQ);
            hit_s   = !found_s && valid_pad_s[cand_s];
            pick_s  = hit_s ? cand_s : pick_s;
            found_s = found_s | hit_s;
        end
        grant_s = 4'b0000;
        grid_in = 3'b000;
        if (credit_s && found_s && !rst) begin
            grant_s = 4'b0001 << pick_s;
            case (pick_s)
                2'd0:    grid_in = data_pad_s[2:0];
                2'd1:    grid_in = data_pad_s[5:3];
                2'd2:    grid_in = data_pad_s[8:6];
                default: grid_in = data_pad_s[11:9];
            endcase
        end else begin
            grant_s = 4'b0000;
            grid_in = 3'b000;
        end
    end

    assign req_ready  = grant_s[NREQ-1:0];
    assign transfer_s = |grant_s;
    assign push_s     = sh_valid_r[LAT-1];
    assign rsp_valid  = (count_r != '0);
    assign pop_s      = rsp_valid & rsp_ready;

    // Round-robin pointer moves only when a grant is actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 2'(NREQ - 1);
        end else if (transfer_s) begin
            last_grant_r <= pick_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Shadow of the grid pipeline: which stages hold a real operand and whose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_valid_r <= '0;
            for (int s = 0; s < LAT; s++) begin
                sh_id_r[s] <= 2'd0;
            end
        end else begin
            sh_valid_r[0] <= transfer_s;
            sh_id_r[0]    <= pick_s;
            for (int s = 1; s < LAT; s++) begin
                sh_valid_r[s] <= sh_valid_r[s-1];
                sh_id_r[s]    <= sh_id_r[s-1];
            end
        end
    end

    // Response FIFO; credit accounting guarantees a push always has room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_r[i] <= 5'b00000;
            end
        end else begin
            if (push_s) begin
                mem_r[wptr_r] <= {grid_out, sh_id_r[LAT-1]};
                wptr_r        <= ptr_inc(wptr_r);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end else begin
                rptr_r <= rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Show-ahead head entry, forced to zero while the FIFO is empty.
    always_comb begin
        if (rsp_valid) begin
            rsp_data = mem_r[rptr_r][4:2];
            rsp_id   = mem_r[rptr_r][1:0];
        end else begin
            rsp_data = 3'b000;
            rsp_id   = 2'b00;
        end
    end

`ifdef GRID_ARB_STATS_EN
    logic stall_s;
    assign stall_s = (|req_valid) && !credit_s;

    // Saturating counters of accepted transfers and credit-starved request cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= 16'd0;
            stat_stall  <= 16'd0;
        end else begin
            if (transfer_s && (stat_issued != 16'hFFFF)) begin
                stat_issued <= stat_issued + 16'd1;
            end else begin
                stat_issued <= stat_issued;
            end
            if (stall_s && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end else begin
                stat_stall <= stat_stall;
            end
        end
    end
`endif

endmodule

// File: doc/grid_issue_arbiter.md
GRID_ISSUE_ARBITER -- requirements
Module: grid_issue_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters, 2..4.
REQ-002 Parameter LAT, default 3: fixed grid latency in clock edges, from grid_in sampled to grid_out valid.
REQ-003 Parameter RSP_DEPTH, default 4: response FIFO depth, at least 2.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester issue request.
REQ-007 req_data  input  3*NREQ  3-bit operand per requester; requester i uses bits [3i+2:3i].
REQ-008 req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are high at posedge.
REQ-009 grid_in  output  3  operand driven to the 3-level AND grid pipeline.
REQ-010 grid_out  input  3  result returned by the grid pipeline.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumer accepts.
REQ-013 rsp_data  output  3  grid result.
REQ-014 rsp_id  output  2  index of the requester that issued the operand.

Function
REQ-015 The grid has no stall. The block SHALL issue at most one operand per cycle, and only when fifo_count + inflight < RSP_DEPTH. A pop in the same cycle SHALL NOT add credit.
REQ-016 Arbitration SHALL be round-robin. The search starts at last_grant+1 modulo NREQ, and req_ready SHALL be asserted only for the first requester found with req_valid high.
REQ-017 req_ready SHALL be all-zero when credit is unavailable or rst is high.
REQ-018 grid_in SHALL equal the granted requester's req_data combinationally, and 3'b000 when nothing is granted.
REQ-019 last_grant SHALL update only on a completed transfer.
REQ-020 A LAT-deep shadow shift register SHALL carry {valid, id} alongside the grid. Stage LAT-1 valid marks grid_out as meaningful in the current cycle.
REQ-021 When shadow stage LAT-1 is valid, the block SHALL write {grid_out, id} into the FIFO at the next posedge. A transfer at edge k therefore makes rsp_valid high after edge k+LAT.
REQ-022 When shadow stage LAT-1 is invalid, grid_out SHALL be ignored.
REQ-023 The FIFO SHALL be show-ahead. rsp_data and rsp_id SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-024 A simultaneous FIFO write and pop SHALL keep the FIFO count unchanged.
REQ-025 FIFO read and write pointers SHALL wrap modulo RSP_DEPTH.
REQ-026 Responses SHALL emerge in issue order. The credit rule SHALL guarantee the FIFO never overflows.
REQ-027 rsp_data SHALL be 3'b000 when rsp_valid=0.

Reset
REQ-028 rst SHALL asynchronously clear:
- shadow valids, FIFO pointers and count;
- last_grant (to NREQ-1, so requester 0 wins first);
- rsp_valid, rsp_data and rsp_id (to 0).
REQ-029 Operands in flight when rst asserts SHALL be discarded with no response. Grid contents that return after reset SHALL be ignored per REQ-022.
REQ-030 Issue SHALL resume on the first posedge after rst deasserts.

Configuration
REQ-031 With macro GRID_ARB_STATS_EN defined, the block SHALL add two outputs:
- stat_issued (16 bits): saturating count of transfers;
- stat_stall (16 bits): saturating count of cycles with any req_valid high but no credit.
Both SHALL be cleared by rst.
REQ-032 Without GRID_ARB_STATS_EN, neither port nor the counters SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-033 Single issue: req_valid=3'b001, req_data[2:0]=3'b111 at edge 0 -> rsp_valid high after edge 3, rsp_data=3'b111 (grid result), rsp_id=0.
REQ-034 Fairness: all three req_valid held high, rsp_ready=1 -> grants rotate 0,1,2,0,1,2 and rsp_id follows that sequence in order.
REQ-035 Backpressure: rsp_ready=0 with continuous requests -> exactly 4 transfers accepted, req_ready then 0, stat_issued=4, stat_stall increments every later cycle. Releasing rsp_ready drains 4 responses in order before new issue completes.
REQ-036 Simultaneous pop/push: FIFO holds 3 and rsp_ready=1 while a shadow-valid result arrives -> count stays 3 and data order is preserved.
REQ-037 Reset mid-flight: 2 operands issued, rst pulsed one cycle later -> no responses appear, rsp_valid=0, and the next grant goes to requester 0.
REQ-038 Idle: req_valid=0 for 10 cycles -> grid_in=3'b000, rsp_valid=0, and no FIFO writes regardless of grid_out value.
